dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 33 +++
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_array.sv | 33 +++
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// addr_err() is only referenced when DMEM_ADDR_CHECK_EN is defined.
package dmem_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BE_W   = 4;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StResp
   } state_e;

   typedef struct packed {
      logic              we;
      logic [WORD_W-1:0] addr;
      logic [WORD_W-1:0] wdata;
      logic [BE_W-1:0]   be;
   } req_t;

   // Misaligned word/halfword access, or any address bit above the array span set.
   function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                     input logic [BE_W-1:0]   be,
                                     input int unsigned       aw);
      logic mis;
      logic oor;
      mis = ((be == 4'hF) && (addr[1:0] != 2'b00)) ||
            (($countones(be) == 2) && addr[0]);
      oor = (addr >> (aw + 2)) != '0;
      return mis || oor;
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the MEM stage and the responder.
interface dmem_responder_if;
   import dmem_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [WORD_W-1:0] req_addr;
   logic [WORD_W-1:0] req_wdata;
   logic [BE_W-1:0]   req_be;
   logic              rsp_valid;
   logic [WORD_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              busy;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 byte-enabled synchronous array; rdata updates only on enabled reads.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [BE_W-1:0]   be,
   input  logic [AW-1:0]     idx,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < BE_W; i++) begin
               if (be[i]) begin
                  mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end else begin
            rdata <= mem_q[idx];
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request in flight, LATENCY wait cycles, single-cycle response.
// Optional address checking is enabled by defining DMEM_ADDR_CHECK_EN.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH   = 32,
   parameter int unsigned LATENCY = 2,
   parameter int unsigned AW      = $clog2(DEPTH)
) (
   input logic             clk,
   input logic             reset,
   dmem_responder_if.slave bus
);

   localparam logic [3:0] LatCnt = 4'(LATENCY);

   state_e            state_q, state_d;
   req_t              req_q, req_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              rd_valid_q, rd_valid_d;
   logic              err_q, err_d;

   req_t              in_req;
   req_t              acc_req;
   logic              accept;
   logic              commit;
   logic              acc_err;
   logic [WORD_W-1:0] arr_rdata;
   logic              unused_addr_bits;

   assign in_req = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata, be: bus.req_be};
   assign accept = bus.req_valid && (state_q == StIdle) && !reset;

   // With zero latency the array is accessed straight from the bus on the accepting edge.
   assign acc_req = (state_q == StIdle) ? in_req : req_q;

`ifdef DMEM_ADDR_CHECK_EN
   assign acc_err = addr_err(acc_req.addr, acc_req.be, AW);
`else
   assign acc_err = 1'b0;
`endif

   assign unused_addr_bits = ^{acc_req.addr[WORD_W-1:AW+2], acc_req.addr[1:0]};

   always_comb begin
      commit = 1'b0;
      if (state_q == StIdle) begin
         commit = accept && (LATENCY == 0);
      end else if (state_q == StWait) begin
         commit = (cnt_q == 4'd1);
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = (LATENCY == 0) ? StResp : StWait;
            end
         end
         StWait: begin
            if (cnt_q == 4'd1) begin
               state_d = StResp;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Captured request, wait counter and response qualifiers
   always_comb begin
      req_d      = req_q;
      cnt_d      = cnt_q;
      rd_valid_d = rd_valid_q;
      err_d      = err_q;
      if (accept) begin
         req_d = in_req;
         cnt_d = LatCnt;
      end else if (state_q == StWait) begin
         cnt_d = cnt_q - 4'd1;
      end
      if (commit) begin
         rd_valid_d = !acc_req.we && !acc_err;
         err_d      = acc_err;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_q      <= '0;
         cnt_q      <= '0;
         rd_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         req_q      <= req_d;
         cnt_q      <= cnt_d;
         rd_valid_q <= rd_valid_d;
         err_q      <= err_d;
      end
   end

   dmem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .en    (commit && !acc_err),
      .we    (acc_req.we),
      .be    (acc_req.be),
      .idx   (acc_req.addr[AW+1:2]),
      .wdata (acc_req.wdata),
      .rdata (arr_rdata)
   );

   // Outputs; rd_valid_q masks the unreset array register and write acks
   always_comb begin
      bus.req_ready = (state_q == StIdle) && !reset;
      bus.busy      = (state_q != StIdle);
      bus.rsp_valid = (state_q == StResp);
      bus.rsp_rdata = rd_valid_q ? arr_rdata : '0;
`ifdef DMEM_ADDR_CHECK_EN
      bus.rsp_err   = err_q;
`else
      bus.rsp_err   = 1'b0;
`endif
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 and LATENCY=0 instances, scoreboard of responses.
module tb_dmem_responder;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   logic clk;
   logic reset;
   logic sel;  // 0 selects the LATENCY=2 instance, 1 the LATENCY=0 instance
   logic valid, we;
   logic [31:0] addr, wdata;
   logic [3:0] be;

   logic ready, rsp_valid, rsp_err, busy;
   logic [31:0] rsp_rdata;

   int total = 0;
   int bad = 0;
   rsp_t exp_q [$];
   logic [31:0] model2 [32];
   logic [31:0] model0 [32];
   logic [31:0] last_rdata;

   dmem_responder_if bus2 ();
   dmem_responder_if bus0 ();

   dmem_responder #(.DEPTH(32), .LATENCY(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));
   dmem_responder #(.DEPTH(32), .LATENCY(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));

   assign bus2.req_valid = valid && !sel;
   assign bus0.req_valid = valid && sel;
   assign bus2.req_we    = we;
   assign bus0.req_we    = we;
   assign bus2.req_addr  = addr;
   assign bus0.req_addr  = addr;
   assign bus2.req_wdata = wdata;
   assign bus0.req_wdata = wdata;
   assign bus2.req_be    = be;
   assign bus0.req_be    = be;

   assign ready     = sel ? bus0.req_ready : bus2.req_ready;
   assign rsp_valid = sel ? bus0.rsp_valid : bus2.rsp_valid;
   assign rsp_rdata = sel ? bus0.rsp_rdata : bus2.rsp_rdata;
   assign rsp_err   = sel ? bus0.rsp_err   : bus2.rsp_err;
   assign busy      = sel ? bus0.busy      : bus2.busy;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic model_err(input logic [31:0] a, input logic [3:0] b);
`ifdef DMEM_ADDR_CHECK_EN
      logic two;
      two = (b == 4'h3) || (b == 4'h5) || (b == 4'h6) || (b == 4'h9) || (b == 4'hA) ||
            (b == 4'hC);
      return ((b == 4'hF) && (a[1:0] != 2'b00)) || (two && a[0]) || (a[31:7] != 25'd0);
`else
      return 1'b0;
`endif
   endfunction

   // Called at a falling edge; returns at the falling edge after the response pulse.
   task automatic do_req(input bit hold, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
      int lat;
      int n;
      rsp_t e, g;
      logic [4:0] ix;
      logic [31:0] m;
      lat = sel ? 0 : 2;
      valid = 1'b1; we = w; addr = a; wdata = d; be = b;
      n = 0;
      while (!ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("accept_timeout", 32'(ready), 32'd1);
      if (!ready) begin
         valid = 1'b0;
         return;
      end
      ix = a[6:2];
      e.err = model_err(a, b);
      e.rdata = '0;
      m = sel ? model0[ix] : model2[ix];
      if (!e.err) begin
         if (w) begin
            for (int i = 0; i < 4; i++) if (b[i]) m[8*i +: 8] = d[8*i +: 8];
            if (sel) model0[ix] = m; else model2[ix] = m;
         end else begin
            e.rdata = m;
         end
      end
      exp_q.push_back(e);
      for (int k = 1; k <= lat + 1; k++) begin
         @(negedge clk);
         if (k == 1 && !hold) valid = 1'b0;
         check("busy_in_flight", 32'(busy), 32'd1);
         check("ready_low", 32'(ready), 32'd0);
         check("rsp_valid_timing", 32'(rsp_valid), 32'(k == lat + 1));
      end
      check("sb_depth", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() != 0) begin
         g = exp_q.pop_front();
         check("rsp_rdata", rsp_rdata, g.rdata);
         check("rsp_err", 32'(rsp_err), 32'(g.err));
      end
      last_rdata = rsp_rdata;
      @(negedge clk);
      check("rsp_pulse_width", 32'(rsp_valid), 32'd0);
      check("busy_clear", 32'(busy), 32'd0);
      check("ready_back", 32'(ready), 32'd1);
   endtask

   initial begin
      reset = 1'b1; sel = 1'b0; valid = 1'b0; we = 1'b0;
      addr = '0; wdata = '0; be = '0; last_rdata = '0;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         check("rst_rsp_rdata", rsp_rdata, 32'd0);
         check("rst_rsp_err", 32'(rsp_err), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("post_rst_ready0", 32'(bus0.req_ready), 32'd1);
      check("post_rst_ready2", 32'(bus2.req_ready), 32'd1);
      sel = 1'b0;
      @(negedge clk);

      // Write then read back with LATENCY=2
      do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      check("t1_write_ack_rdata", last_rdata, 32'd0);
      do_req(0, 1'b0, 32'h10, 32'h0, 4'hF);
      check("t1_read", last_rdata, 32'hDEADBEEF);

      // Byte-enable merge
      do_req(0, 1'b1, 32'h4, 32'h11223344, 4'hF);
      do_req(0, 1'b1, 32'h4, 32'hAABBCCDD, 4'b0101);
      do_req(0, 1'b0, 32'h4, 32'h0, 4'hF);
      check("t2_merge", last_rdata, 32'h11BB33DD);

      // Write with no byte enables leaves the word intact
      do_req(0, 1'b1, 32'h10, 32'h0, 4'h0);
      do_req(0, 1'b0, 32'h10, 32'h0, 4'hF);
      check("be0_no_change", last_rdata, 32'hDEADBEEF);

      // Back-to-back with req_valid held high
      do_req(1, 1'b1, 32'h20, 32'h0000_0001, 4'hF);
      do_req(1, 1'b1, 32'h24, 32'h0000_0002, 4'hF);
      do_req(1, 1'b0, 32'h20, 32'h0, 4'hF);
      check("t3_read_a", last_rdata, 32'h0000_0001);
      do_req(0, 1'b0, 32'h24, 32'h0, 4'hF);
      check("t3_read_b", last_rdata, 32'h0000_0002);

      // Reset during WAIT of a write discards it
      do_req(0, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF);
      do_req(0, 1'b0, 32'h4, 32'h0, 4'hF);
      valid = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'h12345678; be = 4'hF;
      @(negedge clk);
      check("t5_in_wait", 32'(busy), 32'd1);
      valid = 1'b0;
      reset = 1'b1;
      #1;
      check("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("t5_rst_rdata", rsp_rdata, 32'd0);
      check("t5_rst_err", 32'(rsp_err), 32'd0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t5_no_rsp", 32'(rsp_valid), 32'd0);
      end
      do_req(0, 1'b0, 32'h8, 32'h0, 4'hF);
      check("t5_prior_contents", last_rdata, 32'hCAFEF00D);

      // Zero-latency instance
      sel = 1'b1;
      do_req(0, 1'b1, 32'h0, 32'h01020304, 4'hF);
      do_req(0, 1'b0, 32'h0, 32'h0, 4'hF);
      check("t4_read0", last_rdata, 32'h01020304);
`ifndef DMEM_ADDR_CHECK_EN
      do_req(0, 1'b0, 32'h80, 32'h0, 4'hF);
      check("t4_wrap_0x80", last_rdata, 32'h01020304);
      do_req(0, 1'b1, 32'h84, 32'h55667788, 4'hF);
      do_req(0, 1'b0, 32'h4, 32'h0, 4'hF);
      check("t4_wrap_0x84", last_rdata, 32'h55667788);
`endif
      sel = 1'b0;

`ifdef DMEM_ADDR_CHECK_EN
      // Address checking on the LATENCY=2 instance
      do_req(0, 1'b0, 32'h6, 32'h0, 4'hF);
      check("t6_mis_rdata", last_rdata, 32'd0);
      do_req(0, 1'b0, 32'h1000, 32'h0, 4'hF);
      do_req(0, 1'b0, 32'h5, 32'h0, 4'h3);
      do_req(0, 1'b1, 32'h1004, 32'hFFFFFFFF, 4'hF);
      do_req(0, 1'b0, 32'h4, 32'h0, 4'hF);
      check("t6_aligned_ok", last_rdata, 32'h11BB33DD);
      check("t6_aligned_err", 32'(rsp_err), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
